// File: rtl/vram_dbuf_if.sv
// Read/write bus bundle for the double-buffered VRAM: display read port and
// valid/ready write port.
interface vram_dbuf_if #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_data, rd_valid, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_data, rd_valid, wr_ready
    );
endinterface

// File: rtl/vram_dbuf.sv
// Double-buffered video RAM: front page read by the display, back page written or filled,
// page flip committed on vsync.
module vram_dbuf #(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned RD_LATENCY = 1,
    parameter string       INIT_FILE  = "../../artwork/background.txt"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vram_dbuf_if.slave            bus,
    input  logic                  fill_start_i,
    input  logic [DATA_WIDTH-1:0] fill_value_i,
    output logic                  fill_busy_o,
    input  logic                  swap_req_i,
    input  logic                  vsync_i,
    output logic                  swap_pending_o,
    output logic                  front_page_o
);
    typedef enum logic [0:0] {StIdle, StFill} state_e;

    localparam logic [ADDR_WIDTH-1:0] CntOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [2**(ADDR_WIDTH+1)];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
    logic                  front_page_q, front_page_d;
    logic                  swap_pending_q, swap_pending_d;

    logic                  wr_ready;
    logic                  fill_busy;
    logic                  commit;
    logic                  mem_we;
    logic [ADDR_WIDTH:0]   mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [DATA_WIDTH-1:0] rd_pipe_q [RD_LATENCY];
    logic [RD_LATENCY-1:0] rd_vld_q;

    // Contents stay undefined until written or filled.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            fill_cnt_q     <= '0;
            fill_val_q     <= '0;
            front_page_q   <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_cnt_q     <= fill_cnt_d;
            fill_val_q     <= fill_val_d;
            front_page_q   <= front_page_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        fill_val_d = fill_val_q;
        unique case (state_q)
            StIdle: begin
                if (fill_start_i) begin
                    state_d    = StFill;
                    fill_cnt_d = '0;
                    fill_val_d = fill_value_i;
                end
            end
            StFill: begin
                fill_cnt_d = fill_cnt_q + CntOne;
                if (fill_cnt_q == '1) state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ready  = (state_q == StIdle);
        fill_busy = (state_q == StFill);
    end

    // A flip never lands while the fill engine is writing the back page.
    always_comb begin
        commit         = vsync_i && swap_pending_q && (state_q == StIdle);
        front_page_d   = front_page_q ^ commit;
        swap_pending_d = commit ? 1'b0 : (swap_pending_q | swap_req_i);
    end

    always_comb begin
        mem_we    = fill_busy || (bus.wr_valid && wr_ready);
        mem_waddr = fill_busy ? {~front_page_q, fill_cnt_q} : {~front_page_q, bus.wr_addr};
        mem_wdata = fill_busy ? fill_val_q : bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Each stage only advances behind a valid beat, so rd_data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_pipe_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= bus.rd_en;
            if (bus.rd_en) rd_pipe_q[0] <= mem[{front_page_q, bus.rd_addr}];
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign bus.rd_data    = rd_pipe_q[RD_LATENCY-1];
    assign bus.rd_valid   = rd_vld_q[RD_LATENCY-1];
    assign bus.wr_ready   = wr_ready;
    assign fill_busy_o    = fill_busy;
    assign swap_pending_o = swap_pending_q;
    assign front_page_o   = front_page_q;
endmodule

// File: doc/vram_dbuf.md
Name: vram_dbuf

Overview:
Double-buffered, parametrised video RAM for the pixel pipeline. Two pages of 2**ADDR_WIDTH words each:
- The display scan reads the front page through a read port with configurable latency.
- The game/sprite logic writes the back page through a valid/ready write port.
- A built-in fill engine clears the back page to a constant colour.
- Page swap is requested by the writer and committed only on a vsync pulse, so the display never tears.

Parameters:
DATA_WIDTH, 13, pixel word width (colour index/RGB packing).
ADDR_WIDTH, 15, address width of one page; page depth = 2**ADDR_WIDTH.
RD_LATENCY, 1, read latency in cycles, legal 1..4.
INIT_FILE, "../../artwork/background.txt", binary memory image used by the optional init feature.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
rd_en  in  1  read request from the display scan.
rd_addr  in  ADDR_WIDTH  read address within the front page.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data holds data for the request issued RD_LATENCY cycles earlier.
wr_valid  in  1  write request.
wr_ready  out  1  write port can accept.
wr_addr  in  ADDR_WIDTH  write address within the back page.
wr_data  in  DATA_WIDTH  write data.
fill_start  in  1  one-cycle pulse that starts a back-page fill.
fill_value  in  DATA_WIDTH  fill colour, sampled on an accepted fill_start.
fill_busy  out  1  fill engine active.
swap_req  in  1  one-cycle pulse requesting a page flip.
vsync  in  1  one-cycle pulse at the start of vertical blanking.
swap_pending  out  1  flip requested but not yet committed.
front_page  out  1  index of the page currently displayed.

Behaviour:
- Storage:
  - Single array of 2**(ADDR_WIDTH+1) words.
  - Physical address = {page, addr}.
  - Reads use page front_page; writes and fills use ~front_page.
  - Memory contents are not affected by reset.
- Reset (async, rst_n low) forces:
  - front_page=0, swap_pending=0, fill_busy=0, rd_valid=0, rd_data=0, wr_ready=1.
  - FSM to IDLE; fill counter to 0.
- Read path:
  - The page and address are sampled when rd_en=1; the array output is registered.
  - RD_LATENCY-1 further pipeline stages follow; rd_valid travels in a matching shift register.
  - Fully pipelined: one read per cycle.
  - When rd_en=0, rd_data holds its last value.
  - A page swap after a read is issued does not alter data already in flight.
- Write path:
  - wr_ready=1 only in IDLE.
  - A write is accepted when wr_valid && wr_ready and lands in the array at that clock edge.
  - The page used is the back page as seen in the acceptance cycle, i.e. pre-toggle if a swap commits on the same edge.
  - No write buffering; wr_valid while not ready is simply held by the source.
- FSM states: IDLE, FILL.
  - IDLE->FILL on fill_start: latch fill_value, clear counter, fill_busy=1 next cycle.
  - A fill_start coinciding with an accepted write: the write is performed and the fill starts that same edge.
  - FILL: write fill_value to {~front_page, counter} every cycle; counter += 1.
  - FILL->IDLE after the write at counter = 2**ADDR_WIDTH-1. A fill takes exactly 2**ADDR_WIDTH cycles; fill_busy drops the next cycle.
  - fill_start during FILL is ignored.
- Swap:
  - swap_req sets swap_pending; a repeated swap_req while pending is absorbed (no double flip).
  - Commit on a vsync cycle when swap_pending=1 and the FSM is in IDLE: toggle front_page, clear swap_pending.
  - vsync during FILL does not commit; the flip waits for the first vsync after the fill completes.
  - swap_req and vsync in the same cycle with swap_pending=0: no commit that cycle; pending is set.
- Reset mid-fill: the fill is aborted and the back page is left partially filled. Reset mid-read: in-flight reads are discarded and rd_valid=0.

Optional Feature:
VRAM_INIT_EN:
- Defined: the memory is initialised by $readmemb(INIT_FILE) into page 0 and again into page 1, so both pages start with the background image.
- Undefined: no initial block; contents are undefined (X in simulation) until written or filled.

Test Plan:
- ADDR_WIDTH=4, RD_LATENCY=2, after reset: check front_page=0, wr_ready=1, rd_valid=0. Write 0x0A5 to addr 3 (back page 1), swap_req, vsync, rd_en addr 3 -> rd_valid and rd_data=0x0A5 exactly 2 cycles after rd_en; front_page=1.
- fill_start with fill_value=0x1FFF -> fill_busy high 16 cycles and wr_ready=0 throughout. After swap+vsync, read all 16 addresses -> 0x1FFF each.
- swap_req, then vsync while fill_busy=1 -> front_page unchanged and swap_pending=1. First vsync after fill_busy falls -> flip; swap_pending=0.
- Back-to-back rd_en on addresses 0..15 with RD_LATENCY=4 -> 16 consecutive rd_valid cycles, data in order. A swap committing mid-burst does not corrupt already-issued reads.
- Assert rst_n=0 at fill cycle 5 -> fill_busy=0 and wr_ready=1 immediately (async). Addresses 0..4 of the back page hold the fill value; addresses 5..15 keep their prior data.
- With VRAM_INIT_EN and a 16-entry test image: read addr 7 of page 0 after reset -> the image word 7; after a swap, page 1 addr 7 returns the same word.
